display_scan_ctrl: RTL and testbench
====================================

# display_scan_ctrl

Time-multiplexed scan controller for the clock display. It shares a single BCD-to-7-segment decoder across `NDIG` common-electrode digits. Each cycle it drives that decoder's 4-bit BCD input and a one-hot digit enable, with a dead-time blank at the start of every digit slot to suppress ghosting. The digit word is snapshotted once per frame so the display never shows a torn time value.

## Interface
- `NDIG`, 6, number of digits scanned (HH:MM:SS); digit 0 is the least-significant nibble.
- `DIV`, 1000, clock cycles per digit slot; must satisfy `DIV >= 2`.
- `BLANK`, 8, cycles at the start of each slot with all digits off; must satisfy `0 <= BLANK < DIV`.
- `LZB`, 1, when 1, the top digit (`NDIG-1`) shows blank if its value is 0.

Ports:
- `clk`  in  1  the single clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous reset, active-high.
- `en`  in  1  scan enable, level-sensitive.
- `digits_in`  in  4*NDIG  BCD digits; digit k is `[4k+3:4k]`.
- `bcd`  out  4  drives the shared decoder input; 4'hF means blank, because the decoder outputs all segments off for codes above 9.
- `dig_sel`  out  NDIG  one-hot digit enable, active-high; all zero while blanking.
- `frame_tick`  out  1  one-cycle pulse, high in the cycle after a snapshot is taken.

## Operation
- State: `IDLE`, `BLANK`, `SHOW`; slot counter `cnt` (0..DIV-1); digit index `idx` (0..NDIG-1); snapshot register `snap` (4*NDIG bits).
- Reset values:
  - state=`IDLE`, `cnt`=0, `idx`=0, `snap`=0.
  - Outputs: `bcd`=4'hF, `dig_sel`=0, `frame_tick`=0.
  - Reset acts immediately, without waiting for a clock edge, including in the middle of a slot.
- `IDLE` with `en`=1 at an edge:
  - `snap`<=`digits_in`, `idx`<=0, `cnt`<=0, `frame_tick`<=1.
  - Next state is `BLANK`, or `SHOW` directly if `BLANK`=0.
- `cnt` increments every edge while the block is not in `IDLE`. At `cnt`=DIV-1, `cnt` wraps to 0 and `idx` advances.
- `idx` wrap from NDIG-1 to 0 is a frame boundary: `snap`<=`digits_in`, and `frame_tick` pulses for exactly one cycle.
- `BLANK` holds while `cnt` < `BLANK`: `dig_sel`=0, `bcd`=4'hF.
- `SHOW` holds while `cnt` >= `BLANK`:
  - `dig_sel`=1<<`idx`, `bcd`=`snap[4idx+3:4idx]`.
  - Exception: if `LZB`=1, `idx`=NDIG-1 and that nibble is 0, then `bcd`=4'hF while `dig_sel` stays asserted.
- Nibbles A–F pass through unchanged; the decoder blanks them.
- `digits_in` changes in the middle of a frame are invisible until the next frame boundary.
- `en`=0 sampled at any edge while not in `IDLE`:
  - Next state is `IDLE`; `cnt`, `idx`, `bcd` and `dig_sel` return to their reset values.
  - `frame_tick`=0; `snap` is retained.
  - Re-enabling always restarts at digit 0 with a fresh snapshot.
- `en`=1 and a frame wrap on the same edge is an ordinary wrap.

## Timing
- All outputs are registered and glitch-free. `dig_sel`/`bcd` change only at the edge where state, `cnt` or `idx` changes, aligned to the same edge.
- Let E0 be the first edge sampling `en`=1 in `IDLE`:
  - Slot k occupies edges E(k·DIV) to E((k+1)·DIV).
  - Blank for the first `BLANK` cycles of the slot, lit for the remaining `DIV-BLANK` cycles.
- Frame period is exactly NDIG·DIV cycles. `frame_tick` is high in the cycles after E0, E(NDIG·DIV), E(2·NDIG·DIV), and so on.
- Two `dig_sel` bits are never high in the same cycle. At `BLANK`=0, consecutive digits switch on a single edge.
- Disable latency is 1 edge; enable-to-first-lit-digit latency is `BLANK`+1 edges.

## Test plan
All scenarios use `NDIG`=6, `DIV`=10, `BLANK`=2, `LZB`=1.
- Reset: assert `rst` with no clock running -> `bcd`=F, `dig_sel`=0, `frame_tick`=0 immediately.
- Normal scan: `digits_in`=24'h123456, `en`=1 -> `frame_tick` pulses after E0.
  - Cycles 1–2: `dig_sel`=0; cycles 3–10: `dig_sel`=000001, `bcd`=6.
  - Then slots show 5, 4, 3, 2, 1; next `frame_tick` is 60 cycles later.
- Snapshot isolation: change `digits_in` to 24'h000000 at cycle 25 -> slots 3–5 still show 3, 2, 1.
  - The next frame shows 0, 0, 0, 0, 0, then blank: slot 5 has `dig_sel`=100000 with `bcd`=F.
- Disable mid-SHOW in slot 3 -> next cycle `dig_sel`=0, `bcd`=F.
  - Re-enable -> new `frame_tick`, and the scan restarts at `dig_sel`=000001 after 2 blank cycles.
- Async reset mid-slot: pulse `rst` between edges during `SHOW` -> outputs reset instantly; after release with `en`=1, scanning restarts at digit 0.
- Pass-through: `digits_in`=24'h0A0000 with `LZB`=1 -> slot 4 `bcd`=A and slot 5 `bcd`=F, each with its `dig_sel` bit asserted.

Source files
------------

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: time-multiplexed digit scanner that feeds one shared
// BCD-to-7-segment decoder. Each digit slot opens with a short all-off
// dead time to suppress ghosting. The digit word is captured once per frame
// so a time value is never shown half old and half new.
module display_scan_ctrl #(
    parameter int NDIG  = 6,     // digits scanned; digit 0 is the low nibble
    parameter int DIV   = 1000,  // clock cycles per digit slot (>= 2)
    parameter int BLANK = 8,     // dead-time cycles at the start of each slot (< DIV)
    parameter bit LZB   = 1'b1   // blank the top digit when it is zero
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [4*NDIG-1:0]   digits_in,
    output logic [3:0]          bcd,
    output logic [NDIG-1:0]     dig_sel,
    output logic                frame_tick
);

    localparam int CW = (DIV  > 1) ? $clog2(DIV)  : 1;
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

    // Codes above 9 make the shared decoder turn every segment off.
    localparam logic [3:0] BCD_OFF = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BLANK,
        ST_SHOW
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q,   cnt_d;
    logic [IW-1:0]       idx_q,   idx_d;
    logic [4*NDIG-1:0]   snap_q,  snap_d;
    logic [3:0]          bcd_q,   bcd_d;
    logic [NDIG-1:0]     sel_q,   sel_d;
    logic                tick_q,  tick_d;
    logic [3:0]          nib;

    // Next-state and next-output computation. Outputs are derived from the
    // next state so the registered outputs change on the same edge as the
    // state, counter and digit index.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves a value unassigned and no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        tick_d  = 1'b0;
        bcd_d   = BCD_OFF;
        sel_d   = '0;
        nib     = '0;

        if (state_q == ST_IDLE) begin
            if (en) begin
                // Start a fresh frame at digit 0 with a new snapshot.
                snap_d  = digits_in;
                cnt_d   = '0;
                idx_d   = '0;
                tick_d  = 1'b1;
                state_d = (BLANK == 0) ? ST_SHOW : ST_BLANK;
            end
        end else if (!en) begin
            // Disable drops straight back to idle; the snapshot is kept.
            state_d = ST_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            if (cnt_q == CW'(DIV - 1)) begin
                cnt_d = '0;
                if (idx_q == IW'(NDIG - 1)) begin
                    // Frame boundary: the only place the snapshot refreshes.
                    idx_d  = '0;
                    snap_d = digits_in;
                    tick_d = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            state_d = (int'(cnt_d) < BLANK) ? ST_BLANK : ST_SHOW;
        end

        if (state_d == ST_SHOW) begin
            for (int k = 0; k < NDIG; k++) begin
                if (idx_d == IW'(k)) begin
                    sel_d[k] = 1'b1;
                    nib      = snap_d[4*k +: 4];
                end
            end
            // Non-decimal nibbles pass through; the decoder blanks them.
            bcd_d = nib;
            if (LZB && (idx_d == IW'(NDIG - 1)) && (nib == 4'h0)) begin
                bcd_d = BCD_OFF;
            end
        end
    end

    // State, counters, snapshot and output registers; reset acts at once.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            snap_q  <= '0;
            bcd_q   <= BCD_OFF;
            sel_q   <= '0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            bcd_q   <= bcd_d;
            sel_q   <= sel_d;
            tick_q  <= tick_d;
        end
    end

    assign bcd        = bcd_q;
    assign dig_sel    = sel_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl with NDIG=6, DIV=10, BLANK=2, LZB=1.
// Stimulus pushes the hand-computed outputs expected after each edge into a
// queue; a monitor on the falling edge pops and compares them.
module tb_display_scan_ctrl;

    localparam int NDIG  = 6;
    localparam int DIV   = 10;
    localparam int BLANK = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              en  = 1'b0;
    logic [4*NDIG-1:0] digits_in = '0;
    logic [3:0]        bcd;
    logic [NDIG-1:0]   dig_sel;
    logic              frame_tick;
    bit                clk_run = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct packed {
        logic [NDIG-1:0] sel;
        logic [3:0]      bcd;
        logic            ft;
    } exp_t;

    exp_t exp_q[$];

    display_scan_ctrl #(
        .NDIG (NDIG),
        .DIV  (DIV),
        .BLANK(BLANK),
        .LZB  (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .digits_in (digits_in),
        .bcd       (bcd),
        .dig_sel   (dig_sel),
        .frame_tick(frame_tick)
    );

    // Clock only runs once enabled, so reset can be shown to act without it.
    always #5 if (clk_run) clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Apply one edge with the current inputs, then queue the outputs expected after it.
    task automatic step(input logic [NDIG-1:0] sel, input logic [3:0] b, input logic ft);
        exp_t e;
        @(posedge clk);
        #1;
        e.sel = sel;
        e.bcd = b;
        e.ft  = ft;
        exp_q.push_back(e);
    endtask

    task automatic idle_step();
        step('0, 4'hF, 1'b0);
    endtask

    // Cycles c0..c1-1 of slot k: blank for BLANK cycles, then digit k lit with b.
    task automatic run_slot(input int k, input logic [3:0] b, input int c0, input int c1);
        for (int c = c0; c < c1; c++) begin
            if (c < BLANK) step('0, 4'hF, (k == 0) && (c == 0));
            else           step(NDIG'(1 << k), b, 1'b0);
        end
    endtask

    // Monitor: compare the outputs after every edge that has an expectation queued.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cyc++;
            check($sformatf("c%0d dig_sel", cyc),    32'(dig_sel),    32'(e.sel));
            check($sformatf("c%0d bcd", cyc),        32'(bcd),        32'(e.bcd));
            check($sformatf("c%0d frame_tick", cyc), 32'(frame_tick), 32'(e.ft));
        end
    end

    initial begin
        // Reset with no clock running.
        #1 rst = 1'b1;
        #1;
        check("rst_noclk bcd",        32'(bcd),        32'hF);
        check("rst_noclk dig_sel",    32'(dig_sel),    32'h0);
        check("rst_noclk frame_tick", 32'(frame_tick), 32'h0);
        clk_run = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        idle_step();
        idle_step();

        // Frame 1: 123456, digits_in cleared at cycle 25 (mid slot 2).
        digits_in = 24'h123456;
        en = 1'b1;
        run_slot(0, 4'h6, 0, DIV);
        run_slot(1, 4'h5, 0, DIV);
        run_slot(2, 4'h4, 0, 4);
        digits_in = 24'h000000;
        run_slot(2, 4'h4, 4, DIV);
        run_slot(3, 4'h3, 0, DIV);
        run_slot(4, 4'h2, 0, DIV);
        run_slot(5, 4'h1, 0, DIV);

        // Frame 2: all zeros, top digit blanked; input changes mid-frame.
        run_slot(0, 4'h0, 0, DIV);
        run_slot(1, 4'h0, 0, 5);
        digits_in = 24'h0A0000;
        run_slot(1, 4'h0, 5, DIV);
        run_slot(2, 4'h0, 0, DIV);
        run_slot(3, 4'h0, 0, DIV);
        run_slot(4, 4'h0, 0, DIV);
        run_slot(5, 4'hF, 0, DIV);

        // Frame 3: A passes through on digit 4, zero top digit blanked.
        run_slot(0, 4'h0, 0, DIV);
        run_slot(1, 4'h0, 0, DIV);
        run_slot(2, 4'h0, 0, DIV);
        run_slot(3, 4'h0, 0, DIV);
        run_slot(4, 4'hA, 0, DIV);
        run_slot(5, 4'hF, 0, DIV);

        // Frame 4: disable while slot 3 is lit, then re-enable.
        run_slot(0, 4'h0, 0, DIV);
        run_slot(1, 4'h0, 0, DIV);
        run_slot(2, 4'h0, 0, DIV);
        run_slot(3, 4'h0, 0, 5);
        en = 1'b0;
        idle_step();
        idle_step();
        digits_in = 24'h123456;
        en = 1'b1;
        run_slot(0, 4'h6, 0, DIV);
        run_slot(1, 4'h5, 0, DIV);
        run_slot(2, 4'h4, 0, 5);

        // Async reset pulse between edges while digit 2 is lit.
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("rst_mid bcd",        32'(bcd),        32'hF);
        check("rst_mid dig_sel",    32'(dig_sel),    32'h0);
        check("rst_mid frame_tick", 32'(frame_tick), 32'h0);
        #1 rst = 1'b0;
        run_slot(0, 4'h6, 0, DIV);
        run_slot(1, 4'h5, 0, 4);
        en = 1'b0;
        idle_step();
        idle_step();

        @(negedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
